// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and helpers for the write-back port arbiter.
// The request struct is sized by the package defaults AW and DW.
package wb_port_arbiter_pkg;

   localparam int AW = 5;
   localparam int DW = 32;

   localparam logic [AW-1:0] ZERO_REG = 5'd0;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wb_req_t;

   function automatic logic [2**AW-1:0] onehot(input logic [AW-1:0] addr);
      logic [2**AW-1:0] m;
      m       = '0;
      m[addr] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/wb_port_arbiter_fifo.sv
// Small synchronous FIFO of write-back requests.
// It also exposes each slot's valid flag and address, which the arbiter uses to build the pending-write mask.
module wb_fifo
   import wb_port_arbiter_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  wb_req_t                    din,
   input  logic                       pop,
   output wb_req_t                    head,
   output logic [CW-1:0]              count,
   output logic [DEPTH-1:0]           ent_valid,
   output logic [DEPTH-1:0][AW-1:0]   ent_addr
);

   wb_req_t       mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: validity is derived from the pointers and count.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign head = mem[rd_ptr];

   always_comb begin
      logic [PW-1:0] offs;
      offs      = '0;
      ent_valid = '0;
      ent_addr  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offs         = PW'(i) - rd_ptr;
         ent_valid[i] = ({1'b0, offs} < count);
         ent_addr[i]  = mem[i].addr;
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Owns the single register-file write port; the pipeline result wins, auxiliary results
// wait in a small FIFO, and a pending mask plus stall request keep the hazard unit informed.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4,
   parameter int DW         = wb_port_arbiter_pkg::DW,
   parameter int AW         = wb_port_arbiter_pkg::AW
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pipe_wr,
   input  logic [AW-1:0]     pipe_addr,
   input  logic [DW-1:0]     pipe_data,
   input  logic              aux_valid,
   output logic              aux_ready,
   input  logic [AW-1:0]     aux_addr,
   input  logic [DW-1:0]     aux_data,
   output logic              rf_wr,
   output logic [AW-1:0]     rf_addr,
   output logic [DW-1:0]     rf_data,
   output logic [2**AW-1:0]  pend_mask,
   output logic              stall_req
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);

   logic [CW-1:0]             count;
   logic [DEPTH-1:0]          ent_valid;
   logic [DEPTH-1:0][AW-1:0]  ent_addr;
   wb_req_t                   head;
   logic [SW-1:0]             starve;

   logic aux_fire;
   logic aux_keep;
   logic pipe_go;
   logic fifo_ne;
   logic pop;
   logic bypass;
   logic push;

   assign aux_ready = reset && (count < CW'(DEPTH));
   assign aux_fire  = aux_valid && aux_ready;
   // Writes to $0 complete the handshake but are otherwise dropped.
   assign aux_keep  = aux_fire && (aux_addr != ZERO_REG);
   assign pipe_go   = pipe_wr && (pipe_addr != ZERO_REG);
   assign fifo_ne   = (count != '0);
   assign pop       = !pipe_go && fifo_ne;
   assign bypass    = !pipe_go && !fifo_ne && aux_keep;
   assign push      = aux_keep && !bypass;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .din       ('{addr: aux_addr, data: aux_data}),
      .pop       (pop),
      .head      (head),
      .count     (count),
      .ent_valid (ent_valid),
      .ent_addr  (ent_addr)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         rf_wr   <= 1'b0;
         rf_addr <= '0;
         rf_data <= '0;
      end else begin
         rf_wr <= pipe_go || pop || bypass;
         if (pipe_go) begin
            rf_addr <= pipe_addr;
            rf_data <= pipe_data;
         end else if (pop) begin
            rf_addr <= head.addr;
            rf_data <= head.data;
         end else if (bypass) begin
            rf_addr <= aux_addr;
            rf_data <= aux_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         starve <= '0;
      end else if (!fifo_ne || pop) begin
         starve <= '0;
      end else if (starve != SW'(STARVE_MAX)) begin
         starve <= starve + 1'b1;
      end
   end

   assign stall_req = (count == CW'(DEPTH)) || (starve == SW'(STARVE_MAX));

   // The output register is left out: the register file forwards data3 to addr3 readers.
   always_comb begin
      pend_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_valid[i]) pend_mask = pend_mask | onehot(ent_addr[i]);
      end
   end

endmodule
